// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC acknowledge/EOI sequencer.
package pic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK1,
      WAIT2,
      DRIVE
   } state_e;

   localparam int SPURIOUS_IDX = 7;

   // Returns {valid, index} of the lowest set bit.
   function automatic logic [3:0] lowest_set(input logic [7:0] v);
      lowest_set = '0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = {1'b1, 3'(i)};
      end
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational fixed-priority resolver, bit 0 wins.
module pic_priority_resolver
   import pic_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] onehot,
   output logic [2:0]   idx,
   output logic         valid
);

   localparam logic [N-1:0] ONE = 1;

   logic [7:0] req8;
   logic [3:0] res;

   always_comb begin
      req8   = 8'(req);
      res    = lowest_set(req8);
      valid  = res[3];
      idx    = res[2:0];
      onehot = req & (~req + ONE);
   end

endmodule

// File: rtl/pic_inta_sequencer.sv
// INT/INTA handshake, vector drive and EOI mask generation
// for an 8259A-style PIC in 8086 mode.
module pic_inta_sequencer
   import pic_pkg::*;
#(
   parameter int NUM_IRQ      = 3,
   parameter int SPURIOUS_IDX = pic_pkg::SPURIOUS_IDX
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] interrupt_request,
   input  logic [NUM_IRQ-1:0] in_service_register,
   input  logic               inta_n,
   input  logic [4:0]         vector_base,
   input  logic               aeoi_mode,
   input  logic               eoi_valid,
   input  logic               eoi_specific,
   input  logic [2:0]         eoi_level,
   output logic               int_out,
   output logic [NUM_IRQ-1:0] interrupt,
   output logic               latch_in_service,
   output logic [NUM_IRQ-1:0] end_of_interrupt,
   output logic [7:0]         data_out,
   output logic               data_out_en
);

   localparam logic [NUM_IRQ-1:0] ONE = 1;

   state_e             state_q, state_d;
   logic               inta_q;
   logic [NUM_IRQ-1:0] held_q, held_d;
   logic [2:0]         held_idx_q, held_idx_d;
   logic               spur_q, spur_d;
   logic               int_q, int_d;
   logic               latch_q, latch_d;
   logic [NUM_IRQ-1:0] eoi_q, eoi_d;

   logic [NUM_IRQ-1:0] win_oh, isr_oh;
   logic [2:0]         win_idx, isr_idx;
   logic               win_v, isr_v;

   logic               fall, rise, win_ok;
   logic [3:0]         hp_isr;
   logic [NUM_IRQ-1:0] aeoi_m, cmd_m;

   pic_priority_resolver #(.N(NUM_IRQ)) u_irr (
      .req    (interrupt_request),
      .onehot (win_oh),
      .idx    (win_idx),
      .valid  (win_v)
   );

   pic_priority_resolver #(.N(NUM_IRQ)) u_isr (
      .req    (in_service_register),
      .onehot (isr_oh),
      .idx    (isr_idx),
      .valid  (isr_v)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         inta_q     <= 1'b1;
         held_q     <= '0;
         held_idx_q <= '0;
         spur_q     <= 1'b0;
         int_q      <= 1'b0;
         latch_q    <= 1'b0;
         eoi_q      <= '0;
      end else begin
         state_q    <= state_d;
         inta_q     <= inta_n;
         held_q     <= held_d;
         held_idx_q <= held_idx_d;
         spur_q     <= spur_d;
         int_q      <= int_d;
         latch_q    <= latch_d;
         eoi_q      <= eoi_d;
      end
   end

   always_comb begin
      fall   = inta_q & ~inta_n;
      rise   = ~inta_q & inta_n;
      hp_isr = isr_v ? {1'b0, isr_idx} : 4'(NUM_IRQ);
      win_ok = win_v & ({1'b0, win_idx} < hp_isr);

      state_d    = state_q;
      held_d     = held_q;
      held_idx_d = held_idx_q;
      spur_d     = spur_q;
      latch_d    = 1'b0;
      aeoi_m     = '0;
      cmd_m      = '0;

      unique case (state_q)
         IDLE: begin
            if (fall && int_q) begin
               state_d    = ACK1;
               held_d     = win_oh;
               held_idx_d = win_idx;
               spur_d     = ~win_v;
               latch_d    = win_v;
            end
         end
         ACK1: if (rise) state_d = WAIT2;
         WAIT2: if (fall) state_d = DRIVE;
         DRIVE: begin
            if (rise) begin
               state_d    = IDLE;
               spur_d     = 1'b0;
               held_d     = '0;
               held_idx_d = '0;
               if (aeoi_mode && !spur_q) aeoi_m = held_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Out-of-range specific levels clear nothing.
      if (eoi_valid) begin
         if (eoi_specific) begin
            if ({1'b0, eoi_level} < 4'(NUM_IRQ))
               cmd_m = ONE << eoi_level;
         end else begin
            cmd_m = isr_oh;
         end
      end

      int_d = (state_q == IDLE) && win_ok && !(fall && int_q);
      eoi_d = aeoi_m | cmd_m;
   end

   always_comb begin
      int_out          = int_q;
      latch_in_service = latch_q;
      end_of_interrupt = eoi_q;
      interrupt        = (state_q != IDLE) ? held_q : '0;
      data_out_en      = (state_q == DRIVE);
      data_out         = '0;
      if (data_out_en)
         data_out = {vector_base,
                     spur_q ? 3'(SPURIOUS_IDX) : held_idx_q};
   end

endmodule
